sc_downspeedcounter: RTL and testbench

SC_DOWNSPEEDCOUNTER -- requirements
Module: sc_downspeedcounter

---
 rtl/sc_downspeedcounter.sv | 104 ++++++++++
 tb/tb_sc_downspeedcounter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sc_downspeedcounter.sv
// Down-speed counter: synchronous T0 clear, load, saturating brake and optional natural decay.
// Natural decay (prescaler + decay tick) is built only when SC_DOWNSPEEDCOUNTER_DECAY_EN is defined.
module sc_downspeedcounter #(
    parameter int DATAWIDTH  = 24,
    parameter int DECAY_DIV  = 16,
    parameter int BRAKE_STEP = 4
) (
    input  logic                 SC_DOWNSPEEDCOUNTER_CLOCK_50,
    input  logic                 SC_DOWNSPEEDCOUNTER_RESET_InHigh,
    input  logic                 SC_DOWNSPEEDCOUNTER_T0_InLow,
    input  logic                 SC_DOWNSPEEDCOUNTER_load_InLow,
    input  logic [DATAWIDTH-1:0] SC_DOWNSPEEDCOUNTER_load_data_InBUS,
    input  logic                 SC_DOWNSPEEDCOUNTER_brake_InLow,
    output logic [DATAWIDTH-1:0] SC_DOWNSPEEDCOUNTER_data_OutBUS,
    output logic                 SC_DOWNSPEEDCOUNTER_stopped_OutHigh,
    output logic                 SC_DOWNSPEEDCOUNTER_decaytick_OutHigh
);

    typedef enum logic [1:0] {STOPPED, COAST, BRAKE} state_t;

    localparam logic [DATAWIDTH-1:0] BRAKE_AMT = DATAWIDTH'(BRAKE_STEP);

    if (DECAY_DIV < 2 || DECAY_DIV > 65536 || BRAKE_STEP < 1) begin : g_paramCheck
        $error("sc_downspeedcounter: DECAY_DIV or BRAKE_STEP out of range");
    end

    state_t               stateReg, stateNext;
    logic [DATAWIDTH-1:0] speedReg, speedNext;
    logic                 t0Act, loadAct, brakeAct, anyCmd, brakeCmd, decayStep;

    assign t0Act    = ~SC_DOWNSPEEDCOUNTER_T0_InLow;
    assign loadAct  = ~SC_DOWNSPEEDCOUNTER_load_InLow;
    assign brakeAct = ~SC_DOWNSPEEDCOUNTER_brake_InLow;
    assign anyCmd   = t0Act | loadAct | brakeAct;
    // Brake only wins when nothing above it is active, and is ignored once stopped.
    assign brakeCmd = brakeAct & ~t0Act & ~loadAct & (stateReg != STOPPED);

`ifdef SC_DOWNSPEEDCOUNTER_DECAY_EN
    localparam int            PW       = $clog2(DECAY_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DECAY_DIV - 1);

    logic [PW-1:0] preReg;
    logic          decayTickReg;

    assign decayStep = (preReg == PRE_LAST) && (stateReg == COAST) && !anyCmd;

    always_ff @(posedge SC_DOWNSPEEDCOUNTER_CLOCK_50 or posedge SC_DOWNSPEEDCOUNTER_RESET_InHigh) begin
        if (SC_DOWNSPEEDCOUNTER_RESET_InHigh) begin
            preReg       <= '0;
            decayTickReg <= 1'b0;
        end else begin
            decayTickReg <= decayStep;
            if (anyCmd || stateReg == STOPPED || preReg == PRE_LAST)
                preReg <= '0;
            else
                preReg <= preReg + PW'(1);
        end
    end

    assign SC_DOWNSPEEDCOUNTER_decaytick_OutHigh = decayTickReg;
`else
    assign decayStep                             = 1'b0;
    assign SC_DOWNSPEEDCOUNTER_decaytick_OutHigh = 1'b0;
`endif

    always_comb begin
        speedNext = speedReg;
        if (t0Act)
            speedNext = '0;
        else if (loadAct)
            speedNext = SC_DOWNSPEEDCOUNTER_load_data_InBUS;
        else if (brakeCmd)
            speedNext = (speedReg > BRAKE_AMT) ? speedReg - BRAKE_AMT : '0;
        else if (decayStep)
            speedNext = (speedReg != '0) ? speedReg - DATAWIDTH'(1) : '0;
    end

    // Zero speed always parks the FSM, whichever command produced it.
    always_comb begin
        stateNext = stateReg;
        if (speedNext == '0)
            stateNext = STOPPED;
        else if (loadAct)
            stateNext = COAST;
        else if (brakeCmd)
            stateNext = BRAKE;
        else if (stateReg == BRAKE)
            stateNext = COAST;
    end

    always_ff @(posedge SC_DOWNSPEEDCOUNTER_CLOCK_50 or posedge SC_DOWNSPEEDCOUNTER_RESET_InHigh) begin
        if (SC_DOWNSPEEDCOUNTER_RESET_InHigh) begin
            speedReg <= '0;
            stateReg <= STOPPED;
        end else begin
            speedReg <= speedNext;
            stateReg <= stateNext;
        end
    end

    assign SC_DOWNSPEEDCOUNTER_data_OutBUS     = speedReg;
    assign SC_DOWNSPEEDCOUNTER_stopped_OutHigh = (stateReg == STOPPED);

endmodule

// File: tb/tb_sc_downspeedcounter.sv
// Scoreboard bench for sc_downspeedcounter: directed scenarios plus randomized traffic vs a behavioural model.
module tb_sc_downspeedcounter;

    localparam int DW   = 24;
    localparam int DIV  = 16;
    localparam int STEP = 4;
`ifdef SC_DOWNSPEEDCOUNTER_DECAY_EN
    localparam bit DECAY = 1'b1;
`else
    localparam bit DECAY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          t0n = 1'b1, ldn = 1'b1, brn = 1'b1;
    logic [DW-1:0] ldData = '0;
    logic [DW-1:0] dout;
    logic          stopped, tick;

    always #5 clk = ~clk;

    sc_downspeedcounter #(.DATAWIDTH(DW), .DECAY_DIV(DIV), .BRAKE_STEP(STEP)) dut (
        .SC_DOWNSPEEDCOUNTER_CLOCK_50         (clk),
        .SC_DOWNSPEEDCOUNTER_RESET_InHigh     (rst),
        .SC_DOWNSPEEDCOUNTER_T0_InLow         (t0n),
        .SC_DOWNSPEEDCOUNTER_load_InLow       (ldn),
        .SC_DOWNSPEEDCOUNTER_load_data_InBUS  (ldData),
        .SC_DOWNSPEEDCOUNTER_brake_InLow      (brn),
        .SC_DOWNSPEEDCOUNTER_data_OutBUS      (dout),
        .SC_DOWNSPEEDCOUNTER_stopped_OutHigh  (stopped),
        .SC_DOWNSPEEDCOUNTER_decaytick_OutHigh(tick)
    );

    typedef struct {
        logic [DW-1:0] speed;
        logic          stopped;
        logic          tick;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Behavioural model: speed as a plain number, motion mode, idle cycles since last command.
    longint mSpeed = 0;
    int     mMode  = 0;   // 0 stopped, 1 coasting, 2 braking
    int     mIdle  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("speed", longint'(dout), longint'(e.speed));
            check("stopped", longint'(stopped), longint'(e.stopped));
            check("decaytick", longint'(tick), longint'(e.tick));
        end
    end

    // Called at a falling edge: drives one cycle of inputs, predicts the result, waits one cycle.
    task automatic cyc(input bit t0, input bit ld, input bit br, input logic [DW-1:0] d);
        exp_t e;
        bit   dec;
        bit   cmd;
        dec    = 1'b0;
        cmd    = t0 || ld || br;
        t0n    = !t0;
        ldn    = !ld;
        brn    = !br;
        ldData = d;
        if (t0)
            mSpeed = 0;
        else if (ld)
            mSpeed = longint'(d);
        else if (br && mMode != 0)
            mSpeed = (mSpeed > STEP) ? mSpeed - STEP : 0;
        else if (mMode != 0) begin
            mIdle++;
            if (DECAY && mMode == 1 && (mIdle % DIV) == 0) begin
                mSpeed = mSpeed - 1;
                dec    = 1'b1;
            end
        end
        if (cmd || mMode == 0) mIdle = 0;
        if (mSpeed == 0)             mMode = 0;
        else if (ld)                 mMode = 1;
        else if (br && mMode != 0)   mMode = 2;
        else                         mMode = 1;
        e.speed   = DW'(mSpeed);
        e.stopped = (mMode == 0);
        e.tick    = dec;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0);
    endtask

    // Called at a falling edge: asserts reset between clock edges and checks outputs before any edge.
    task automatic asyncReset();
        #2;
        rst = 1'b1;
        t0n = 1'b1; ldn = 1'b1; brn = 1'b1;
        #1;
        check("rst_speed", longint'(dout), 0);
        check("rst_stopped", longint'(stopped), 1);
        check("rst_tick", longint'(tick), 0);
        mSpeed = 0; mMode = 0; mIdle = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [DW-1:0] randData();
        int k;
        k = int'($urandom_range(0, 9));
        if (k == 0) return '0;
        if (k == 1) return {DW{1'b1}};
        if (k == 2) return DW'($urandom_range(STEP - 1, STEP + 1));
        return DW'($urandom_range(1, 40));
    endfunction

    initial begin
        @(negedge clk);
        asyncReset();

        // Load 10 and coast all the way down.
        cyc(1'b0, 1'b1, 1'b0, DW'(10));
        idle(10 * DIV + 4);
        // Brake from 10: 6, 2, then saturate at 0.
        cyc(1'b0, 1'b1, 1'b0, DW'(10));
        cyc(1'b0, 1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, 1'b1, '0);
        idle(2);
        // Everything at once: T0 wins.
        cyc(1'b0, 1'b1, 1'b0, DW'(50));
        cyc(1'b1, 1'b1, 1'b1, DW'(99));
        idle(2);
        // Load beats brake and restarts the prescaler.
        cyc(1'b0, 1'b1, 1'b0, DW'(50));
        idle(5);
        cyc(1'b0, 1'b1, 1'b1, DW'(99));
        idle(DIV + 4);
        // Load of zero stays stopped; brake while stopped does nothing.
        cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b1, '0);
        // Async reset mid-brake at speed 30.
        cyc(1'b0, 1'b1, 1'b0, DW'(38));
        cyc(1'b0, 1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, 1'b1, '0);
        asyncReset();
        // Async reset right while a decay tick is showing.
        cyc(1'b0, 1'b1, 1'b0, DW'(5));
        idle(DIV);
        asyncReset();
        // Inputs evaluated normally on the first edge after release; long hold with no commands.
        cyc(1'b0, 1'b1, 1'b0, DW'(10));
        idle(100);

        for (int i = 0; i < 4000; i++) begin
            bit quiet;
            int p;
            quiet = ((i / 200) % 2) == 1;
            p     = quiet ? 1 : 6;
            if ($urandom_range(0, 999) < 3) asyncReset();
            cyc($urandom_range(0, 99) < (quiet ? 0 : 2),
                $urandom_range(0, 99) < p,
                $urandom_range(0, 99) < 2 * p,
                randData());
        end

        t0n = 1'b1; ldn = 1'b1; brn = 1'b1;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", longint'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
